tl_rx_fc_update_gen: RTL and testbench

- Receive-side flow-control credit return stage. Sits directly downstream of the DW-to-credit converter.
- Accumulates header and data credits freed as TLPs drain from the RX buffers into per-type CREDITS_ALLOCATED counters (P, NP, CPL).
- Decides when to schedule an UpdateFC. Presents the request to the DLL DLLP generator over a valid/ready handshake.

---
 rtl/tl_rx_fc_update_gen.sv | 254 +++++++++++++++++++++++++
 tb/tb_tl_rx_fc_update_gen.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_rx_fc_update_gen.sv
// ---------------------------------------------------------------------------
// tl_rx_fc_update_gen
//
// Receive-side flow-control credit return stage. Freed header/data credits
// (one TLP per cycle at most) are added to per-type CREDITS_ALLOCATED counters
// for P, NP and CPL. A per-type pending count tracks credits freed since the
// last UpdateFC for that type. When a type has enough pending credit, or the
// periodic timer has marked it urgent, an UpdateFC request is raised toward
// the DLLP generator.
//
// Handshake: upd_valid rises in the cycle after a type is granted and stays
// high, with upd_type / upd_hdr_fc / upd_data_fc stable, until the cycle in
// which upd_valid & upd_ready are both high. That cycle is the transfer;
// upd_valid is low in the following cycle. upd_valid never depends
// combinationally on upd_ready.
//
// Ports:
//   clk, arst_n      core clock, asynchronous active-low reset
//   fc_init_done     DLL flow-control init complete (level); low forces INIT
//   data_scale       scale factor, captured only while fc_init_done is low
//   free_valid/type  one TLP drained this cycle, type 00=P 01=NP 10=CPL
//   free_hdr/data    header / data credits released by that TLP
//   upd_valid/ready  UpdateFC request handshake
//   upd_type         type of the request
//   upd_hdr_fc       HdrFC snapshot, masked to the scaled field width
//   upd_data_fc      DataFC snapshot, masked to the scaled field width
//   dbg_state        current FSM state (00=INIT, 01=IDLE, 10=REQ)
// ---------------------------------------------------------------------------
module tl_rx_fc_update_gen #(
  parameter int PAYLOAD_IN_CREDS = 9,
  parameter int HDR_THRESH       = 4,
  parameter int DATA_THRESH      = 32,
  parameter int UPDATE_TIMER     = 1024,
  parameter int INIT_P_HDR       = 32,
  parameter int INIT_P_DATA      = 256,
  parameter int INIT_NP_HDR      = 32,
  parameter int INIT_NP_DATA     = 16,
  parameter int INIT_CPL_HDR     = 0,
  parameter int INIT_CPL_DATA    = 0
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        fc_init_done,
  input  logic [1:0]                  data_scale,
  input  logic                        free_valid,
  input  logic [1:0]                  free_type,
  input  logic                        free_hdr,
  input  logic [PAYLOAD_IN_CREDS-1:0] free_data,
  output logic                        upd_valid,
  output logic [1:0]                  upd_type,
  output logic [11:0]                 upd_hdr_fc,
  output logic [15:0]                 upd_data_fc,
  input  logic                        upd_ready,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_REQ  = 2'd2
  } state_t;

  // A type advertised with zero header and zero data credits is infinite:
  // it never accumulates and never asks for an update.
  localparam logic [2:0] INF_MASK = {
    (INIT_CPL_HDR == 0) && (INIT_CPL_DATA == 0),
    (INIT_NP_HDR  == 0) && (INIT_NP_DATA  == 0),
    (INIT_P_HDR   == 0) && (INIT_P_DATA   == 0)
  };
  localparam logic [7:0]  HDR_TH   = 8'(HDR_THRESH);
  localparam logic [15:0] DATA_TH  = 16'(DATA_THRESH);
  localparam logic [15:0] TMR_LAST = 16'(UPDATE_TIMER - 1);

  function automatic logic [11:0] init_hdr(input logic [1:0] t);
    case (t)
      2'd0:    return 12'(INIT_P_HDR);
      2'd1:    return 12'(INIT_NP_HDR);
      default: return 12'(INIT_CPL_HDR);
    endcase
  endfunction

  function automatic logic [15:0] init_data(input logic [1:0] t);
    case (t)
      2'd0:    return 16'(INIT_P_DATA);
      2'd1:    return 16'(INIT_NP_DATA);
      default: return 16'(INIT_CPL_DATA);
    endcase
  endfunction

  // Round-robin successor over the three types P -> NP -> CPL -> P.
  function automatic logic [1:0] rr_next(input logic [1:0] t);
    return (t == 2'd2) ? 2'd0 : t + 2'd1;
  endfunction

  state_t      state_q, state_d;
  logic [11:0] hdr_cnt_q   [3];
  logic [15:0] data_cnt_q  [3];
  logic [7:0]  pend_hdr_q  [3];
  logic [15:0] pend_data_q [3];
  logic [7:0]  pend_hdr_d  [3];
  logic [15:0] pend_data_d [3];
  logic [8:0]  hdr_sum     [3];
  logic [16:0] data_sum    [3];
  logic [2:0]  urgent_q, urgent_d;
  logic [2:0]  free_hit, dirty_d, elig;
  logic [3:0]  elig_ext;
  logic [1:0]  last_q, grant_type, cand1, cand2;
  logic        grant_any;
  logic [15:0] timer_q;
  logic        timer_wrap;
  logic        handshake;
  logic [1:0]  scale_q;
  logic [11:0] hdr_mask;
  logic [15:0] data_mask;

  assign upd_valid  = (state_q == ST_REQ);
  assign dbg_state  = state_q;
  assign handshake  = upd_valid && upd_ready && fc_init_done;
  assign timer_wrap = fc_init_done && (state_q != ST_INIT) && (timer_q == TMR_LAST);

  always_comb begin
    hdr_mask  = 12'h0FF;
    data_mask = 16'h0FFF;
    case (scale_q)
      2'b10: begin
        hdr_mask  = 12'h3FF;
        data_mask = 16'h3FFF;
      end
      2'b11: begin
        hdr_mask  = 12'hFFF;
        data_mask = 16'hFFFF;
      end
      default: ;
    endcase
  end

  // Next pending values include this cycle's free, so a free that crosses a
  // threshold makes its type eligible in the same cycle. On a transfer the
  // granted type restarts from whatever arrives in that same cycle.
  always_comb begin
    free_hit = '0;
    dirty_d  = '0;
    elig     = '0;
    urgent_d = urgent_q;
    for (int t = 0; t < 3; t++) begin
      free_hit[t]    = free_valid && (free_type == 2'(t)) && !INF_MASK[t];
      hdr_sum[t]     = {1'b0, pend_hdr_q[t]} + {8'd0, free_hit[t] & free_hdr};
      data_sum[t]    = {1'b0, pend_data_q[t]} + (free_hit[t] ? 17'(free_data) : 17'd0);
      pend_hdr_d[t]  = hdr_sum[t][8]   ? 8'hFF    : hdr_sum[t][7:0];
      pend_data_d[t] = data_sum[t][16] ? 16'hFFFF : data_sum[t][15:0];
      if (handshake && (upd_type == 2'(t))) begin
        pend_hdr_d[t]  = {7'd0, free_hit[t] & free_hdr};
        pend_data_d[t] = free_hit[t] ? 16'(free_data) : 16'd0;
      end
      dirty_d[t] = (pend_hdr_d[t] != '0) || (pend_data_d[t] != '0);
      elig[t]    = (state_q == ST_IDLE) && dirty_d[t] &&
                   ((pend_hdr_d[t] >= HDR_TH) || (pend_data_d[t] >= DATA_TH) || urgent_q[t]);
      // A timer wrap marking a type dirty wins over the transfer clearing it.
      if (timer_wrap && dirty_d[t]) begin
        urgent_d[t] = 1'b1;
      end else if (handshake && (upd_type == 2'(t))) begin
        urgent_d[t] = 1'b0;
      end
    end
  end

  // Round-robin pick starting after the last granted type.
  always_comb begin
    elig_ext   = {1'b0, elig};
    cand1      = rr_next(last_q);
    cand2      = rr_next(cand1);
    grant_any  = 1'b0;
    grant_type = 2'd0;
    if (elig_ext[cand1]) begin
      grant_any  = 1'b1;
      grant_type = cand1;
    end else if (elig_ext[cand2]) begin
      grant_any  = 1'b1;
      grant_type = cand2;
    end else if (elig_ext[last_q]) begin
      grant_any  = 1'b1;
      grant_type = last_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!fc_init_done) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT: state_d = ST_IDLE;
        ST_IDLE: if (grant_any) state_d = ST_REQ;
        ST_REQ:  if (upd_ready) state_d = ST_IDLE;
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int t = 0; t < 3; t++) begin
        hdr_cnt_q[t]   <= init_hdr(2'(t));
        data_cnt_q[t]  <= init_data(2'(t));
        pend_hdr_q[t]  <= '0;
        pend_data_q[t] <= '0;
      end
      urgent_q    <= '0;
      timer_q     <= '0;
      last_q      <= 2'd2;   // first search starts at P
      scale_q     <= 2'b00;
      upd_type    <= 2'd0;
      upd_hdr_fc  <= '0;
      upd_data_fc <= '0;
    end else if (!fc_init_done) begin
      for (int t = 0; t < 3; t++) begin
        hdr_cnt_q[t]   <= init_hdr(2'(t));
        data_cnt_q[t]  <= init_data(2'(t));
        pend_hdr_q[t]  <= '0;
        pend_data_q[t] <= '0;
      end
      urgent_q <= '0;
      timer_q  <= '0;
      scale_q  <= data_scale;
    end else if (state_q != ST_INIT) begin
      for (int t = 0; t < 3; t++) begin
        if (free_hit[t]) begin
          hdr_cnt_q[t]  <= hdr_cnt_q[t] + {11'd0, free_hdr};
          data_cnt_q[t] <= data_cnt_q[t] + 16'(free_data);
        end
        pend_hdr_q[t]  <= pend_hdr_d[t];
        pend_data_q[t] <= pend_data_d[t];
      end
      urgent_q <= urgent_d;
      timer_q  <= timer_wrap ? 16'd0 : timer_q + 16'd1;
      if (grant_any) begin
        // Snapshot uses the counter before this cycle's free is added.
        last_q      <= grant_type;
        upd_type    <= grant_type;
        upd_hdr_fc  <= hdr_cnt_q[grant_type] & hdr_mask;
        upd_data_fc <= data_cnt_q[grant_type] & data_mask;
      end
    end
  end

endmodule

// File: tb/tb_tl_rx_fc_update_gen.sv
// ---------------------------------------------------------------------------
// tb_tl_rx_fc_update_gen
//
// Directed scenarios followed by randomized traffic. A behavioural model of
// the credit-return rules (plain integer counters, modulo arithmetic) predicts
// upd_valid every cycle and pushes every expected UpdateFC into exp_q; each
// DUT transfer is checked against the head of that queue.
// ---------------------------------------------------------------------------
module tb_tl_rx_fc_update_gen;

  localparam int UT      = 1024;
  localparam int HDR_TH  = 4;
  localparam int DATA_TH = 32;

  logic        clk;
  logic        arst_n;
  logic        fc_init_done;
  logic [1:0]  data_scale;
  logic        free_valid;
  logic [1:0]  free_type;
  logic        free_hdr;
  logic [8:0]  free_data;
  logic        upd_valid;
  logic [1:0]  upd_type;
  logic [11:0] upd_hdr_fc;
  logic [15:0] upd_data_fc;
  logic        upd_ready;
  logic [1:0]  dbg_state;

  tl_rx_fc_update_gen dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .fc_init_done (fc_init_done),
    .data_scale   (data_scale),
    .free_valid   (free_valid),
    .free_type    (free_type),
    .free_hdr     (free_hdr),
    .free_data    (free_data),
    .upd_valid    (upd_valid),
    .upd_type     (upd_type),
    .upd_hdr_fc   (upd_hdr_fc),
    .upd_data_fc  (upd_data_fc),
    .upd_ready    (upd_ready),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks;
  int failures;
  int cpl_seen;
  logic [29:0] exp_q[$];   // {type[1:0], hdr[11:0], data[15:0]}

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int init_hdr [3] = '{32, 32, 0};
  int init_data[3] = '{256, 16, 0};
  int m_hdr[3], m_data[3], m_ph[3], m_pd[3];
  bit m_urg[3];
  int m_timer, m_mode, m_last, m_scale, m_rtype;   // m_mode: 0 init, 1 idle, 2 requesting

  function automatic int hdr_mod(int s);
    return (s <= 1) ? 256 : (s == 2) ? 1024 : 4096;
  endfunction

  function automatic int data_mod(int s);
    return (s <= 1) ? 4096 : (s == 2) ? 16384 : 65536;
  endfunction

  task automatic model_load_init();
    for (int t = 0; t < 3; t++) begin
      m_hdr[t]  = init_hdr[t];
      m_data[t] = init_data[t];
      m_ph[t]   = 0;
      m_pd[t]   = 0;
      m_urg[t]  = 0;
    end
    m_timer = 0;
  endtask

  task automatic model_reset();
    model_load_init();
    m_mode  = 0;
    m_last  = 2;
    m_scale = 0;
    m_rtype = 0;
    exp_q.delete();
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int  was_mode;
    bit  hit[3];
    bit  hs;
    bit  found;
    int  t;
    logic [29:0] e;
    if (!fc_init_done) begin
      model_load_init();
      m_scale = data_scale;
      m_mode  = 0;
      exp_q.delete();
      return;
    end
    if (m_mode == 0) begin
      m_mode = 1;
      return;
    end
    was_mode = m_mode;
    hs = (m_mode == 2) && upd_ready;
    if (hs && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("xfer_type", upd_type, e[29:28]);
      check_eq("xfer_hdr", upd_hdr_fc, e[27:16]);
      check_eq("xfer_data", upd_data_fc, e[15:0]);
    end
    for (int k = 0; k < 3; k++) begin
      hit[k] = free_valid && (int'(free_type) == k) && !(init_hdr[k] == 0 && init_data[k] == 0);
      if (hit[k]) begin
        m_ph[k] = (m_ph[k] + free_hdr > 255) ? 255 : m_ph[k] + free_hdr;
        m_pd[k] = (m_pd[k] + free_data > 65535) ? 65535 : m_pd[k] + free_data;
      end
    end
    if (hs) begin
      m_ph[m_rtype]  = hit[m_rtype] ? int'(free_hdr) : 0;
      m_pd[m_rtype]  = hit[m_rtype] ? int'(free_data) : 0;
      m_urg[m_rtype] = 0;
      m_mode = 1;
    end
    if (was_mode == 1) begin
      found = 0;
      for (int k = 1; k <= 3; k++) begin
        t = (m_last + k) % 3;
        if (!found && (m_ph[t] != 0 || m_pd[t] != 0) &&
            (m_ph[t] >= HDR_TH || m_pd[t] >= DATA_TH || m_urg[t])) begin
          found = 1;
          e = {2'(t), 12'(m_hdr[t] % hdr_mod(m_scale)), 16'(m_data[t] % data_mod(m_scale))};
          exp_q.push_back(e);
          m_rtype = t;
          m_last  = t;
          m_mode  = 2;
        end
      end
    end
    if (m_timer == UT - 1) begin
      m_timer = 0;
      for (int k = 0; k < 3; k++) if (m_ph[k] != 0 || m_pd[k] != 0) m_urg[k] = 1;
    end else begin
      m_timer++;
    end
    for (int k = 0; k < 3; k++) begin
      if (hit[k]) begin
        m_hdr[k]  = (m_hdr[k] + free_hdr) % 4096;
        m_data[k] = (m_data[k] + free_data) % 65536;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_eq("upd_valid", {31'd0, upd_valid}, (m_mode == 2) ? 32'd1 : 32'd0);
    if (upd_valid && upd_type == 2'd2) cpl_seen++;
  endtask

  task automatic set_free(input int ty, input int h, input int d);
    free_valid = 1'b1;
    free_type  = 2'(ty);
    free_hdr   = 1'(h);
    free_data  = 9'(d);
  endtask

  task automatic no_free();
    free_valid = 1'b0;
    free_type  = 2'd0;
    free_hdr   = 1'b0;
    free_data  = 9'd0;
  endtask

  task automatic restart(input int s);
    no_free();
    upd_ready    = 1'b0;
    fc_init_done = 1'b0;
    data_scale   = 2'(s);
    tick();
    fc_init_done = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!upd_valid && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, {31'd0, upd_valid}, 32'd1);
  endtask

  task automatic accept();
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
  endtask

  // Data counter of P pushed past 4095, then a fresh request reports it.
  task automatic scale_wrap(input int s, input int exp_data);
    restart(s);
    set_free(0, 0, 511);
    tick();
    repeat (8) tick();
    no_free();
    accept();
    set_free(0, 0, 40);
    tick();
    no_free();
    check_eq("wrap_valid", {31'd0, upd_valid}, 32'd1);
    check_eq("wrap_hdr", upd_hdr_fc, 32'd32);
    check_eq("wrap_data", upd_data_fc, exp_data);
    accept();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    checks       = 0;
    failures     = 0;
    cpl_seen     = 0;
    arst_n       = 1'b0;
    fc_init_done = 1'b0;
    data_scale   = 2'd0;
    upd_ready    = 1'b0;
    no_free();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'd0, upd_valid}, 32'd0);
    check_eq("rst_type", upd_type, 32'd0);
    check_eq("rst_hdr", upd_hdr_fc, 32'd0);
    check_eq("rst_data", upd_data_fc, 32'd0);
    check_eq("rst_state", dbg_state, 32'd0);
    arst_n = 1'b1;

    // Four P frees: the 4th crosses the header threshold and is granted with
    // the pre-free counters 35/262.
    restart(0);
    repeat (4) begin
      set_free(0, 1, 2);
      tick();
    end
    no_free();
    check_eq("thr_valid", {31'd0, upd_valid}, 32'd1);
    check_eq("thr_type", upd_type, 32'd0);
    check_eq("thr_hdr", upd_hdr_fc, 32'd35);
    check_eq("thr_data", upd_data_fc, 32'd262);
    repeat (3) tick();
    check_eq("thr_hold_hdr", upd_hdr_fc, 32'd35);
    accept();
    check_eq("thr_done", {31'd0, upd_valid}, 32'd0);

    // Single NP free below threshold: only the timer can send it.
    restart(0);
    set_free(1, 1, 0);
    tick();
    no_free();
    repeat (20) tick();
    check_eq("np_quiet", {31'd0, upd_valid}, 32'd0);
    wait_valid("np_timer_wait", 1100);
    check_eq("np_type", upd_type, 32'd1);
    check_eq("np_hdr", upd_hdr_fc, 32'd33);
    check_eq("np_data", upd_data_fc, 32'd16);
    accept();

    // P and NP urgent together: round robin from after NP gives P, then NP.
    restart(0);
    set_free(0, 1, 0);
    tick();
    set_free(1, 1, 0);
    tick();
    no_free();
    wait_valid("rr1_wait", 1100);
    check_eq("rr1_first", upd_type, 32'd0);
    accept();
    wait_valid("rr1_wait2", 5);
    check_eq("rr1_second", upd_type, 32'd1);
    accept();

    // After a P grant, a simultaneous P/NP eligibility goes to NP first.
    restart(0);
    set_free(0, 0, 40);
    tick();
    no_free();
    accept();
    set_free(0, 1, 0);
    tick();
    set_free(1, 1, 0);
    tick();
    no_free();
    wait_valid("rr2_wait", 1100);
    check_eq("rr2_first", upd_type, 32'd1);
    accept();
    wait_valid("rr2_wait2", 5);
    check_eq("rr2_second", upd_type, 32'd0);
    accept();

    // Field masking: 256 + 9*511 = 4855.
    scale_wrap(0, 4855 % 4096);
    scale_wrap(3, 4855);

    // Free to P in the P transfer cycle stays pending and is in the next count.
    restart(3);
    set_free(0, 0, 40);
    tick();
    set_free(0, 1, 5);
    upd_ready = 1'b1;
    tick();
    upd_ready = 1'b0;
    set_free(0, 0, 40);
    tick();
    no_free();
    check_eq("hsfree_valid", {31'd0, upd_valid}, 32'd1);
    check_eq("hsfree_hdr", upd_hdr_fc, 32'd33);
    check_eq("hsfree_data", upd_data_fc, 32'd301);
    accept();

    // fc_init_done dropped while requesting: request abandoned, INIT reload.
    set_free(0, 0, 40);
    tick();
    no_free();
    fc_init_done = 1'b0;
    tick();
    check_eq("drop_valid", {31'd0, upd_valid}, 32'd0);
    check_eq("drop_state", dbg_state, 32'd0);
    fc_init_done = 1'b1;
    tick();
    set_free(0, 0, 40);
    tick();
    no_free();
    check_eq("drop_hdr", upd_hdr_fc, 32'd32);
    check_eq("drop_data", upd_data_fc, 32'd256);
    accept();

    // Asynchronous reset while requesting.
    set_free(0, 0, 40);
    tick();
    no_free();
    #2;
    arst_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, upd_valid}, 32'd0);
    check_eq("arst_state", dbg_state, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;

    // Randomized traffic, CPL included.
    for (int i = 0; i < 3000; i++) begin
      fc_init_done = ($urandom_range(0, 1499) != 0);
      data_scale   = 2'($urandom_range(0, 3));
      free_valid   = 1'($urandom_range(0, 1));
      free_type    = 2'($urandom_range(0, 3));
      free_hdr     = ($urandom_range(0, 3) != 0);
      free_data    = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 12));
      upd_ready    = ($urandom_range(0, 3) == 0);
      tick();
    end
    no_free();
    fc_init_done = 1'b1;
    upd_ready    = 1'b1;
    repeat (5) tick();

    check_eq("cpl_never", cpl_seen, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
